// File: rtl/wand_bus_arbiter_pkg.sv
// Shared types and defaults for the wired-AND bus arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package wand_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 16;
  localparam int CNT_W_DEF    = 5;

endpackage

// File: rtl/wand_bus_arbiter_if.sv
// Requester/line bundle between the agents and the wired-AND arbiter.
// Latency: none, wiring only.
// Backpressure: req is a level held by each agent until it is granted and done.
interface wand_bus_arbiter_if #(
  parameter int N_REQ = wand_arb_pkg::N_REQ_DEF
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] drv;
  logic             ext_bus;
  logic [N_REQ-1:0] gnt;
  logic             bus_out;
  logic             busy;
  logic             collision;
  logic             timeout;

  // agent / environment side
  modport master (
    output req, drv, ext_bus,
    input  gnt, bus_out, busy, collision, timeout
  );

  // arbiter side
  modport slave (
    input  req, drv, ext_bus,
    output gnt, bus_out, busy, collision, timeout
  );
endinterface

// File: rtl/wand_bus_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; valid simply reports whether any request is set.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             valid
);

  logic [2*N-1:0] dbl_rot;
  logic [N-1:0]   rot;
  logic [N-1:0]   sel_rot;
  logic [2*N-1:0] dbl_back;
  logic           found;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate the pick back.
  always_comb begin
    dbl_rot  = {req, req} >> ptr;
    rot      = dbl_rot[N-1:0];
    sel_rot  = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        sel_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
    dbl_back = {sel_rot, sel_rot} << ptr;
    onehot   = dbl_back[2*N-1:N];
    valid    = |req;
  end

endmodule

// File: rtl/wand_bus_arbiter.sv
// Round-robin owner arbitration for a shared wired-AND line with collision/timeout.
// Latency: req->gnt 1 clk from IDLE; one RELEASE turnaround clk between owners.
// Backpressure: requesters wait on gnt; owners are cut on collision or MAX_HOLD.
module wand_bus_arbiter
  import wand_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  wand_bus_arbiter_if.slave   bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
  logic             collision_q, collision_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] pick_onehot;
  logic             pick_valid;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             owner_drv;
  logic             owner_req;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .valid  (pick_valid)
  );

  // Decode the current owner index from the one-hot grant and derive the next pointer.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) owner_idx = PTR_W'(i);
    end
    if (owner_idx == PTR_W'(N_REQ - 1)) next_ptr = '0;
    else                                next_ptr = owner_idx + PTR_W'(1);
    owner_drv = |(bus.drv & gnt_q);
    owner_req = |(bus.req & gnt_q);
  end

  // Next-state logic: collision beats voluntary release, which beats the hold limit.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    hold_cnt_d  = hold_cnt;
    rr_ptr_d    = rr_ptr;
    collision_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d      = pick_onehot;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt + CNT_W'(1);
        // ext_bus is only looked at here, so X/0 outside ownership is harmless
        if (owner_drv && !bus.ext_bus) begin
          collision_d = 1'b1;
          state_d     = ST_RELEASE;
        end else if (!owner_req) begin
          state_d     = ST_RELEASE;
        end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
          timeout_d   = 1'b1;
          state_d     = ST_RELEASE;
        end
        if (state_d == ST_RELEASE) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant, counters and flag registers; reset clears the grant without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      collision_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      hold_cnt    <= hold_cnt_d;
      rr_ptr      <= rr_ptr_d;
      collision_q <= collision_d;
      timeout_q   <= timeout_d;
    end
  end

  // Non-owners contribute recessive '1'; the owner's drv passes straight through.
  assign bus.gnt       = gnt_q;
  assign bus.bus_out   = &(bus.drv | ~gnt_q);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.collision = collision_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Directed bench for wand_bus_arbiter with an ownership-level reference model.
// Latency: model tracks grants at clock granularity.
// Backpressure: ext_bus is the DUT contribution ANDed with a bench-controlled pull.
module tb_wand_bus_arbiter;
  import wand_arb_pkg::*;

  localparam int N  = 4;
  localparam int MH = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] req_v    = 4'b0000;
  logic [3:0] drv_v    = 4'b0000;
  logic       ext_pull = 1'b1;

  always #5 clk = ~clk;

  wand_bus_arbiter_if #(.N_REQ(N)) bus_if ();

  assign bus_if.req     = req_v;
  assign bus_if.drv     = drv_v;
  assign bus_if.ext_bus = bus_if.bus_out & ext_pull;

  wand_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the line, for how long, and whether we are in turnaround.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  bit   m_rel   = 1'b0;
  bit   m_coll  = 1'b0;
  bit   m_tmo   = 1'b0;
  bit   m_end;
  logic m_ext;
  int   m_idx;

  function automatic logic m_bus_out();
    if (m_owner < 0) return 1'b1;
    return drv_v[m_owner[1:0]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
      m_rel = 1'b0; m_coll = 1'b0; m_tmo = 1'b0;
    end else begin
      m_ext  = m_bus_out() & ext_pull;
      m_coll = 1'b0;
      m_tmo  = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        m_end = 1'b0;
        if (drv_v[m_owner[1:0]] && !m_ext) begin
          m_coll = 1'b1; m_end = 1'b1;
        end else if (!req_v[m_owner[1:0]]) begin
          m_end = 1'b1;
        end else if (m_held == MH) begin
          m_tmo = 1'b1; m_end = 1'b1;
        end
        if (m_end) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_rel   = 1'b1;
        end
      end else if (m_rel) begin
        m_rel = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (m_owner < 0 && req_v[m_idx[1:0]]) begin
            m_owner = m_idx;
            m_held  = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [3:0] exp_g;
  always @(negedge clk) begin
    exp_g = 4'b0000;
    if (m_owner >= 0) exp_g[m_owner[1:0]] = 1'b1;
    chk("cyc_gnt",       {4'b0, bus_if.gnt},       {4'b0, exp_g});
    chk("cyc_bus_out",   {7'b0, bus_if.bus_out},   {7'b0, m_bus_out()});
    chk("cyc_busy",      {7'b0, bus_if.busy},      {7'b0, (m_owner >= 0) || m_rel});
    chk("cyc_collision", {7'b0, bus_if.collision}, {7'b0, m_coll});
    chk("cyc_timeout",   {7'b0, bus_if.timeout},   {7'b0, m_tmo});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int n_gnt;

  initial begin
    // 1: reset and idle
    cyc(); cyc();
    rst_n = 1'b1;
    at_neg();
    chk("rst_gnt",     {4'b0, bus_if.gnt},     8'h00);
    chk("rst_bus_out", {7'b0, bus_if.bus_out}, 8'h01);
    chk("rst_busy",    {7'b0, bus_if.busy},    8'h00);
    repeat (10) cyc();
    at_neg();
    chk("idle_gnt", {4'b0, bus_if.gnt}, 8'h00);

    // 2: two requesters from ptr 0, owner 0 drives 0
    cyc();
    req_v = 4'b0101; drv_v = 4'b0000;
    cyc();
    at_neg();
    chk("t2_gnt0",    {4'b0, bus_if.gnt},     8'h01);
    chk("t2_bus_out", {7'b0, bus_if.bus_out}, 8'h00);
    cyc(); cyc();
    req_v = 4'b0100;
    cyc();
    at_neg();
    chk("t2_rel_gnt",  {4'b0, bus_if.gnt},  8'h00);
    chk("t2_rel_busy", {7'b0, bus_if.busy}, 8'h01);
    cyc();
    at_neg();
    chk("t2_idle_busy", {7'b0, bus_if.busy}, 8'h00);
    cyc();
    at_neg();
    chk("t2_gnt2", {4'b0, bus_if.gnt}, 8'h04);
    cyc();
    req_v = 4'b0000;
    cyc(); cyc();

    // 3: lone requester 1 hits the hold limit and is regranted
    req_v = 4'b0010; drv_v = 4'b0010;
    cyc();
    n_gnt = 0;
    for (int k = 0; k < 20; k++) begin
      at_neg();
      if (bus_if.gnt != 4'b0010) break;
      n_gnt++;
      cyc();
    end
    chk("t3_hold_cycles", 8'(n_gnt), 8'd16);
    chk("t3_timeout",     {7'b0, bus_if.timeout},   8'h01);
    chk("t3_no_coll",     {7'b0, bus_if.collision}, 8'h00);
    cyc();
    at_neg();
    chk("t3_gap_gnt", {4'b0, bus_if.gnt},     8'h00);
    chk("t3_tmo_off", {7'b0, bus_if.timeout}, 8'h00);
    cyc();
    at_neg();
    chk("t3_regrant", {4'b0, bus_if.gnt}, 8'h02);
    cyc();
    req_v = 4'b0000; drv_v = 4'b0000;
    cyc(); cyc();

    // 4: owner 2 drives 1, line pulled low on GRANT cycle 3
    req_v = 4'b0100; drv_v = 4'b0100;
    cyc(); cyc(); cyc();
    ext_pull = 1'b0;
    cyc();
    at_neg();
    chk("t4_collision", {7'b0, bus_if.collision}, 8'h01);
    chk("t4_timeout",   {7'b0, bus_if.timeout},   8'h00);
    chk("t4_gnt",       {4'b0, bus_if.gnt},       8'h00);
    cyc();
    ext_pull = 1'b1;

    // 5: collision and req drop together; collision wins
    cyc();
    at_neg();
    chk("t5_gnt2", {4'b0, bus_if.gnt}, 8'h04);
    cyc(); cyc();
    ext_pull = 1'b0; req_v = 4'b0000;
    cyc();
    at_neg();
    chk("t5_collision", {7'b0, bus_if.collision}, 8'h01);
    chk("t5_timeout",   {7'b0, bus_if.timeout},   8'h00);
    cyc();
    ext_pull = 1'b1; drv_v = 4'b0000;
    cyc();

    // 6: asynchronous reset mid-grant, then pointer restarts at 0
    req_v = 4'b1010;
    cyc();
    at_neg();
    chk("t6_gnt3", {4'b0, bus_if.gnt}, 8'h08);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_gnt",  {4'b0, bus_if.gnt},     8'h00);
    chk("t6_async_bus",  {7'b0, bus_if.bus_out}, 8'h01);
    chk("t6_async_busy", {7'b0, bus_if.busy},    8'h00);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    at_neg();
    chk("t6_after_rst", {4'b0, bus_if.gnt}, 8'h02);
    cyc();
    req_v = 4'b0000;
    cyc(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
